decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width for pc and immediate; legal values are 32 and 64.
REQ-002 Parameter SKID, default 1; 1 selects a two-entry skid buffer with registered in_ready, 0 selects a single output register with combinational in_ready.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous pipeline kill.
REQ-006 in_valid  input  1; in_ready  output  1; in_inst  input  32; in_pc  input  XLEN: upstream beat.
REQ-007 out_valid  output  1; out_ready  input  1: downstream handshake.
REQ-008 out_opcode 7, out_rd 5, out_rs1 5, out_rs2 5, out_fn3 3, out_fn7 7, out_imm XLEN, out_fmt 3, out_illegal 1, out_pc XLEN, out_inst 32: all outputs, all registered.

Function
REQ-009 A beat SHALL transfer on a clock edge where valid and ready are both high; latency from input acceptance to out_valid SHALL be 1 cycle.
REQ-010 Throughput SHALL be 1 beat/cycle while out_ready is high, for both SKID values.
REQ-011 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-012 SKID=0: in_ready = !out_valid || out_ready.
REQ-013 SKID=1: in_ready SHALL equal "skid entry empty". A beat accepted while the output is stalled SHALL go to the skid entry. It SHALL move to the output on the first edge with out_ready=1. Order SHALL be preserved, with no loss and no duplication.
REQ-014 Field extraction: opcode=[6:0], rd=[11:7], fn3=[14:12], rs1=[19:15], rs2=[24:20], fn7=[31:25].
REQ-015 out_fmt SHALL be one of R, I, S, B, U, J, X, selected by opcode.
REQ-016 Immediate rules:
- R and X formats: immediate SHALL be 0.
- I, S, B, U, J formats: immediate SHALL be built per the RV32I base encoding.
- All formats: bit 31 SHALL sign-extend to XLEN.
REQ-017 out_illegal=1 on any of:
- inst[1:0] != 2'b11;
- opcode outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM;
- JALR with fn3 != 0;
- BRANCH with fn3 in {2,3};
- LOAD with fn3 of 3 or 6 when XLEN=32, or fn3 of 7 in any case;
- STORE with fn3 > 2 (XLEN=32) or fn3 > 3 (XLEN=64);
- OP with fn7 not in {0x00, 0x20}, or fn7=0x20 with fn3 not in {0,5};
- OP-IMM shift with illegal fn7.
REQ-018 An illegal beat SHALL still be forwarded, with out_fmt=X, out_imm=0 and raw fields intact.
REQ-019 On a flush edge, out_valid and the skid entry SHALL clear, and a beat handshaked in that same cycle SHALL be discarded.
REQ-020 Flush and reset SHALL take priority over every handshake.

Reset
REQ-021 While rst_n=0: out_valid=0, skid empty, and all out_* data SHALL be 0.
REQ-022 in_ready SHALL read 1 during and after reset for both SKID values; no beat SHALL be captured while rst_n=0.
REQ-023 Reset asserted mid-transfer SHALL drop all held beats; the first edge after release SHALL accept a new beat normally.

Structure
REQ-024 Package decode_pkg SHALL hold:
- the opcode constants;
- the fmt_e enum (R=0, I=1, S=2, B=3, U=4, J=5, X=7);
- the fn3 load/store/branch constants.
REQ-025 Immediate generation SHALL live in a combinational sub-module imm_gen, parameterised by XLEN.
REQ-026 Skid and output registers SHALL be in decode_stage; no other sub-modules.

Verification
REQ-027 in_inst=0x00848933 accepted, XLEN=32 -> one cycle later: opcode=0x33, rd=18, rs1=9, rs2=8, fn3=0, fn7=0, fmt=R, imm=0, illegal=0.
REQ-028 Back-to-back stream of these instructions with imm checked, XLEN=64, out_ready=1 -> one output per cycle:
- 0x10100493 -> imm=0x101;
- 0x0082a223 -> imm=4 (S);
- 0x014c6463 -> imm=8 (B), fn3=6;
- 0x7ff080e7 -> imm=0x7FF (I);
- 0x0000006f -> imm=0 (J);
- 0x872370b7 -> imm=0xFFFFFFFF87237000 (U).
REQ-029 SKID=1, out_ready=0 for 3 cycles, in_valid=1 continuously -> exactly 2 beats accepted and in_ready=0 from the 3rd cycle; on out_ready=1 both beats emerge in order, then in_ready=1.
REQ-030 in_inst=0xFFFFFFFF, 0x0000_0033 with fn7=0x01 (0x02000033), 0x00002067 -> out_illegal=1, fmt=X, imm=0 for each.
REQ-031 flush pulsed with output and skid both full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle beat never appears.
REQ-032 rst_n dropped mid-stall, async between edges -> out_valid=0 immediately; after release, the first accepted 0x00848933 appears 1 cycle later.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I/RV64I decode constants: major opcodes, instruction formats and
// the fn3 encodings for loads, stores and branches.
package decode_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_X = 3'd7
    } fmt_e;

    localparam logic [2:0] F3_LB   = 3'd0;
    localparam logic [2:0] F3_LH   = 3'd1;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_LD   = 3'd3;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;
    localparam logic [2:0] F3_LWU  = 3'd6;
    localparam logic [2:0] F3_SB   = 3'd0;
    localparam logic [2:0] F3_SH   = 3'd1;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_SD   = 3'd3;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // Format implied by the opcode alone; legality is judged separately.
    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_LUI, OP_AUIPC:                          return FMT_U;
            OP_JAL:                                    return FMT_J;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_MISC_MEM, OP_SYSTEM:                    return FMT_I;
            OP_BRANCH:                                 return FMT_B;
            OP_STORE:                                  return FMT_S;
            OP_OP:                                     return FMT_R;
            default:                                   return FMT_X;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate builder: assembles the RV32I immediate for the given
// format and sign-extends bit 31 of the instruction to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm32 = {inst[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Instruction decode pipeline stage: one registered output slot, optionally
// backed by a skid entry so that in_ready comes straight from a flop.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_fn3,
    output logic [6:0]      out_fn7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst
);

    localparam bit IS64 = (XLEN == 64);

    logic            out_valid_reg;
    logic [31:0]     out_inst_reg;
    logic [XLEN-1:0] out_pc_reg;
    logic [XLEN-1:0] out_imm_reg;
    logic [2:0]      out_fmt_reg;
    logic            out_illegal_reg;

    logic            skid_valid;
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] skid_pc;

    logic            accept;
    logic            out_free;
    logic            load_out;
    logic [31:0]     src_inst;
    logic [XLEN-1:0] src_pc;

    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_reg || out_ready;
    assign load_out = out_free && (skid_valid || accept);

    // A held skid beat is always older than anything on the input.
    assign src_inst = skid_valid ? skid_inst : in_inst;
    assign src_pc   = skid_valid ? skid_pc   : in_pc;

    logic [6:0] src_opcode;
    logic [2:0] src_fn3;
    logic [6:0] src_fn7;
    logic       dec_illegal;
    logic [2:0] dec_fmt;
    logic [XLEN-1:0] dec_imm;

    assign src_opcode = src_inst[6:0];
    assign src_fn3    = src_inst[14:12];
    assign src_fn7    = src_inst[31:25];

    always_comb begin
        dec_illegal = (src_inst[1:0] != 2'b11);
        case (src_opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_MISC_MEM, OP_SYSTEM: ;
            OP_JALR:   if (src_fn3 != 3'd0) dec_illegal = 1'b1;
            OP_BRANCH: if (src_fn3 == 3'd2 || src_fn3 == 3'd3) dec_illegal = 1'b1;
            OP_LOAD: begin
                if (src_fn3 == 3'd7) dec_illegal = 1'b1;
                if (!IS64 && (src_fn3 == F3_LD || src_fn3 == F3_LWU)) dec_illegal = 1'b1;
            end
            OP_STORE:  if (src_fn3 > (IS64 ? F3_SD : F3_SW)) dec_illegal = 1'b1;
            OP_OP: begin
                if (src_fn7 != 7'h00 && src_fn7 != 7'h20) dec_illegal = 1'b1;
                else if (src_fn7 == 7'h20 && src_fn3 != 3'd0 && src_fn3 != 3'd5) dec_illegal = 1'b1;
            end
            OP_IMM: begin
                // RV64 shifts borrow inst[25] as shamt[5], so only the top six bits are checked.
                if (IS64) begin
                    if (src_fn3 == 3'd1 && src_inst[31:26] != 6'h00) dec_illegal = 1'b1;
                    if (src_fn3 == 3'd5 && src_inst[31:26] != 6'h00 && src_inst[31:26] != 6'h10)
                        dec_illegal = 1'b1;
                end else begin
                    if (src_fn3 == 3'd1 && src_fn7 != 7'h00) dec_illegal = 1'b1;
                    if (src_fn3 == 3'd5 && src_fn7 != 7'h00 && src_fn7 != 7'h20) dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_fmt = dec_illegal ? FMT_X : fmt_of(src_opcode);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (src_inst),
        .fmt  (dec_fmt),
        .imm  (dec_imm)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic            skid_valid_reg;
            logic [31:0]     skid_inst_reg;
            logic [XLEN-1:0] skid_pc_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_valid_reg <= 1'b0;
                    skid_inst_reg  <= '0;
                    skid_pc_reg    <= '0;
                end else if (flush) begin
                    skid_valid_reg <= 1'b0;
                end else if (accept && !out_free) begin
                    skid_valid_reg <= 1'b1;
                    skid_inst_reg  <= in_inst;
                    skid_pc_reg    <= in_pc;
                end else if (out_free) begin
                    skid_valid_reg <= 1'b0;
                end
            end

            assign skid_valid = skid_valid_reg;
            assign skid_inst  = skid_inst_reg;
            assign skid_pc    = skid_pc_reg;
            assign in_ready   = !skid_valid_reg;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_inst  = '0;
            assign skid_pc    = '0;
            assign in_ready   = !out_valid_reg || out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            out_inst_reg    <= '0;
            out_pc_reg      <= '0;
            out_imm_reg     <= '0;
            out_fmt_reg     <= '0;
            out_illegal_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (out_free) begin
            out_valid_reg <= load_out;
            if (load_out) begin
                out_inst_reg    <= src_inst;
                out_pc_reg      <= src_pc;
                out_imm_reg     <= dec_imm;
                out_fmt_reg     <= dec_fmt;
                out_illegal_reg <= dec_illegal;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_inst    = out_inst_reg;
    assign out_pc      = out_pc_reg;
    assign out_imm     = out_imm_reg;
    assign out_fmt     = out_fmt_reg;
    assign out_illegal = out_illegal_reg;
    assign out_opcode  = out_inst_reg[6:0];
    assign out_rd      = out_inst_reg[11:7];
    assign out_fn3     = out_inst_reg[14:12];
    assign out_rs1     = out_inst_reg[19:15];
    assign out_rs2     = out_inst_reg[24:20];
    assign out_fn7     = out_inst_reg[31:25];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: an RV32 skid-buffered instance (a) and an RV64 instance
// with a single output register (b), driven from one linear sequence.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_illegal_a;
    logic [31:0] in_inst_a, in_pc_a, out_imm_a, out_pc_a, out_inst_a;
    logic [6:0]  out_opcode_a, out_fn7_a;
    logic [4:0]  out_rd_a, out_rs1_a, out_rs2_a;
    logic [2:0]  out_fn3_a, out_fmt_a;

    logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_illegal_b;
    logic [31:0] in_inst_b, out_inst_b;
    logic [63:0] in_pc_b, out_imm_b, out_pc_b;
    logic [6:0]  out_opcode_b, out_fn7_b;
    logic [4:0]  out_rd_b, out_rs1_b, out_rs2_b;
    logic [2:0]  out_fn3_b, out_fmt_b;

    decode_stage #(.XLEN(32), .SKID(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_inst(in_inst_a), .in_pc(in_pc_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_opcode(out_opcode_a), .out_rd(out_rd_a), .out_rs1(out_rs1_a), .out_rs2(out_rs2_a),
        .out_fn3(out_fn3_a), .out_fn7(out_fn7_a), .out_imm(out_imm_a), .out_fmt(out_fmt_a),
        .out_illegal(out_illegal_a), .out_pc(out_pc_a), .out_inst(out_inst_a)
    );

    decode_stage #(.XLEN(64), .SKID(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_inst(in_inst_b), .in_pc(in_pc_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_opcode(out_opcode_b), .out_rd(out_rd_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b),
        .out_fn3(out_fn3_b), .out_fn7(out_fn7_b), .out_imm(out_imm_b), .out_fmt(out_fmt_b),
        .out_illegal(out_illegal_b), .out_pc(out_pc_b), .out_inst(out_inst_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] inst);
        in_valid_a = 1'b1;
        in_inst_a  = inst;
        in_pc_a    = in_pc_a + 32'd4;
        step();
        in_valid_a = 1'b0;
    endtask

    logic [31:0] s_inst [0:5];
    logic [63:0] s_imm  [0:5];
    logic [31:0] t_inst [0:6];
    logic        t_ill  [0:6];
    logic [2:0]  t_fmt  [0:6];
    logic [31:0] t_imm  [0:6];

    initial begin
        s_inst[0] = 32'h10100493; s_imm[0] = 64'h101;
        s_inst[1] = 32'h0082a223; s_imm[1] = 64'h4;
        s_inst[2] = 32'h014c6463; s_imm[2] = 64'h8;
        s_inst[3] = 32'h7ff080e7; s_imm[3] = 64'h7ff;
        s_inst[4] = 32'h0000006f; s_imm[4] = 64'h0;
        s_inst[5] = 32'h872370b7; s_imm[5] = 64'hFFFFFFFF87237000;

        t_inst[0] = 32'hFFFFFFFF; t_ill[0] = 1'b1; t_fmt[0] = 3'd7; t_imm[0] = 32'h0;
        t_inst[1] = 32'h02000033; t_ill[1] = 1'b1; t_fmt[1] = 3'd7; t_imm[1] = 32'h0;
        t_inst[2] = 32'h00002067; t_ill[2] = 1'b1; t_fmt[2] = 3'd7; t_imm[2] = 32'h0;
        t_inst[3] = 32'h00003003; t_ill[3] = 1'b1; t_fmt[3] = 3'd7; t_imm[3] = 32'h0;
        t_inst[4] = 32'hFE000EE3; t_ill[4] = 1'b0; t_fmt[4] = 3'd3; t_imm[4] = 32'hFFFFFFFC;
        t_inst[5] = 32'h40105093; t_ill[5] = 1'b0; t_fmt[5] = 3'd1; t_imm[5] = 32'h401;
        t_inst[6] = 32'h02101093; t_ill[6] = 1'b1; t_fmt[6] = 3'd7; t_imm[6] = 32'h0;

        flush_a = 0; in_valid_a = 1; in_inst_a = 32'h00848933; in_pc_a = 32'h0; out_ready_a = 1;
        flush_b = 0; in_valid_b = 1; in_inst_b = 32'h00848933; in_pc_b = 64'h0; out_ready_b = 1;

        // Reset with valid input offered: nothing may be captured.
        step();
        step();
        chk("rst_out_valid_a", 64'(out_valid_a), 64'd0);
        chk("rst_in_ready_a",  64'(in_ready_a),  64'd1);
        chk("rst_out_inst_a",  64'(out_inst_a),  64'd0);
        chk("rst_out_imm_a",   64'(out_imm_a),   64'd0);
        chk("rst_out_valid_b", 64'(out_valid_b), 64'd0);
        chk("rst_in_ready_b",  64'(in_ready_b),  64'd1);
        in_valid_a = 0;
        in_valid_b = 0;
        rst_n = 1;
        step();

        // RV64, single register: back-to-back stream, one result per cycle.
        for (int i = 0; i < 6; i++) begin
            in_valid_b = 1;
            in_inst_b  = s_inst[i];
            in_pc_b    = 64'h1000 + 64'(4 * i);
            step();
            $display("[TB] b stream %0d inst=%h imm=%h", i, out_inst_b, out_imm_b);
            chk("b_stream_valid", 64'(out_valid_b), 64'd1);
            chk("b_stream_inst",  64'(out_inst_b),  64'(s_inst[i]));
            chk("b_stream_imm",   out_imm_b,        s_imm[i]);
            chk("b_stream_pc",    out_pc_b,         64'h1000 + 64'(4 * i));
            chk("b_stream_ready", 64'(in_ready_b),  64'd1);
            if (i == 2) chk("b_stream_fn3", 64'(out_fn3_b), 64'd6);
        end
        in_valid_b = 0;
        step();
        chk("b_drain_valid", 64'(out_valid_b), 64'd0);

        // RV64 stall: combinational in_ready drops and output holds.
        out_ready_b = 0;
        in_valid_b  = 1;
        in_inst_b   = 32'h00848933;
        step();
        chk("b_stall_ready", 64'(in_ready_b),  64'd0);
        in_inst_b = 32'h10100493;
        step();
        chk("b_stall_hold",  64'(out_inst_b),  64'h00848933);
        in_valid_b  = 0;
        out_ready_b = 1;
        step();
        chk("b_stall_drain", 64'(out_valid_b), 64'd0);

        // RV32 R-type field extraction.
        in_valid_a = 1; in_inst_a = 32'h00848933; in_pc_a = 32'h80;
        step();
        in_valid_a = 0;
        $display("[TB] a rtype inst=%h fmt=%0d", out_inst_a, out_fmt_a);
        chk("a_r_valid",  64'(out_valid_a),   64'd1);
        chk("a_r_opcode", 64'(out_opcode_a),  64'h33);
        chk("a_r_rd",     64'(out_rd_a),      64'd18);
        chk("a_r_rs1",    64'(out_rs1_a),     64'd9);
        chk("a_r_rs2",    64'(out_rs2_a),     64'd8);
        chk("a_r_fn3",    64'(out_fn3_a),     64'd0);
        chk("a_r_fn7",    64'(out_fn7_a),     64'd0);
        chk("a_r_fmt",    64'(out_fmt_a),     64'd0);
        chk("a_r_imm",    64'(out_imm_a),     64'd0);
        chk("a_r_ill",    64'(out_illegal_a), 64'd0);
        chk("a_r_pc",     64'(out_pc_a),      64'h80);

        // RV32 legality and immediate corner cases.
        for (int i = 0; i < 7; i++) begin
            send_a(t_inst[i]);
            $display("[TB] a table %0d inst=%h ill=%0d fmt=%0d imm=%h",
                     i, out_inst_a, out_illegal_a, out_fmt_a, out_imm_a);
            chk("a_t_valid", 64'(out_valid_a),   64'd1);
            chk("a_t_inst",  64'(out_inst_a),    64'(t_inst[i]));
            chk("a_t_ill",   64'(out_illegal_a), 64'(t_ill[i]));
            chk("a_t_fmt",   64'(out_fmt_a),     64'(t_fmt[i]));
            chk("a_t_imm",   64'(out_imm_a),     64'(t_imm[i]));
        end
        step();
        chk("a_t_drain", 64'(out_valid_a), 64'd0);

        // Skid: three stalled cycles with continuous input accept exactly two beats.
        out_ready_a = 0;
        in_valid_a  = 1;
        in_inst_a   = 32'h00100093;
        step();
        chk("sk_c1_ready", 64'(in_ready_a), 64'd1);
        chk("sk_c1_out",   64'(out_inst_a), 64'h00100093);
        in_inst_a = 32'h00200113;
        step();
        chk("sk_c2_ready", 64'(in_ready_a), 64'd0);
        chk("sk_c2_hold",  64'(out_inst_a), 64'h00100093);
        in_inst_a = 32'h00300193;
        step();
        chk("sk_c3_ready", 64'(in_ready_a), 64'd0);
        chk("sk_c3_hold",  64'(out_inst_a), 64'h00100093);
        out_ready_a = 1;
        step();
        $display("[TB] a skid release out=%h in_ready=%0d", out_inst_a, in_ready_a);
        chk("sk_rel_out",   64'(out_inst_a),  64'h00200113);
        chk("sk_rel_valid", 64'(out_valid_a), 64'd1);
        chk("sk_rel_ready", 64'(in_ready_a),  64'd1);
        step();
        chk("sk_third_out", 64'(out_inst_a), 64'h00300193);
        in_valid_a = 0;
        step();
        chk("sk_empty", 64'(out_valid_a), 64'd0);

        // Flush with output and skid full, then a flush coinciding with a handshake.
        out_ready_a = 0;
        in_valid_a  = 1;
        in_inst_a   = 32'h00400213;
        step();
        in_inst_a = 32'h00500293;
        step();
        chk("fl_full_ready", 64'(in_ready_a), 64'd0);
        in_inst_a = 32'h00600313;
        flush_a   = 1;
        step();
        flush_a = 0;
        chk("fl_out_valid", 64'(out_valid_a), 64'd0);
        chk("fl_in_ready",  64'(in_ready_a),  64'd1);
        in_inst_a = 32'h00700393;
        flush_a   = 1;
        step();
        flush_a = 0;
        chk("fl_hs_drop", 64'(out_valid_a), 64'd0);
        in_valid_a  = 0;
        out_ready_a = 1;
        step();
        $display("[TB] a after flush valid=%0d", out_valid_a);
        chk("fl_no_ghost", 64'(out_valid_a), 64'd0);

        // Asynchronous reset mid-stall, released between edges.
        out_ready_a = 0;
        send_a(32'h00800413);
        send_a(32'h00900493);
        #3;
        rst_n = 0;
        #1;
        chk("ar_out_valid", 64'(out_valid_a), 64'd0);
        chk("ar_in_ready",  64'(in_ready_a),  64'd1);
        chk("ar_out_inst",  64'(out_inst_a),  64'd0);
        @(posedge clk);
        #2;
        rst_n       = 1;
        in_valid_a  = 1;
        in_inst_a   = 32'h00848933;
        out_ready_a = 1;
        step();
        in_valid_a = 0;
        $display("[TB] a post-reset out=%h valid=%0d", out_inst_a, out_valid_a);
        chk("ar_first_valid", 64'(out_valid_a), 64'd1);
        chk("ar_first_inst",  64'(out_inst_a),  64'h00848933);
        chk("ar_first_rd",    64'(out_rd_a),    64'd18);
        step();
        chk("ar_no_old", 64'(out_valid_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
